// File: rtl/bpred_table_ctrl.sv
// bpred_table_ctrl: 2-bit counter table with init sweep, lookup/update arbitration and a FIFO of pending updates
module bpred_table_ctrl #(
  parameter int IDX_W     = 4,
  parameter int QDEPTH    = 4,
  parameter int MAX_DEFER = 3
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       lookup_valid,
  input  logic [IDX_W-1:0]           lookup_idx,
  output logic                       lookup_ready,
  output logic                       pred_valid,
  output logic                       pred_taken,
  input  logic                       upd_valid,
  input  logic [IDX_W-1:0]           upd_idx,
  input  logic                       upd_taken,
  output logic                       upd_ready,
  output logic                       busy,
  output logic [$clog2(QDEPTH):0]    q_count
);
  localparam int N  = 1 << IDX_W;
  localparam int AW = $clog2(QDEPTH);
  localparam int CW = AW + 1;
  localparam int DW = $clog2(MAX_DEFER + 1);
  typedef enum logic {INIT, RUN} state_t;
  state_t            state;
  logic [IDX_W-1:0]  sweep;
  logic [1:0]        tbl [N];
  logic [IDX_W:0]    q [QDEPTH];
  logic [AW-1:0]     head, tail;
  logic [DW-1:0]     defer;
  logic              lk, commit, push, ht;
  logic [IDX_W-1:0]  hidx;
  logic [1:0]        cur, nxt;
  assign busy         = state == INIT;
  assign upd_ready    = !busy && q_count < CW'(QDEPTH);
  assign lookup_ready = !busy && !(q_count != '0 && defer == DW'(MAX_DEFER));
  always_comb begin
    lk          = lookup_valid && lookup_ready;
    commit      = !busy && q_count != '0 && !lk;
    push        = upd_valid && upd_ready;
    {hidx, ht}  = q[head];
    cur         = tbl[hidx];
    nxt         = ht ? (cur == 2'b11 ? cur : cur + 2'b01) : (cur == 2'b00 ? cur : cur - 2'b01);
  end
  // storage arrays carry no reset; the sweep defines the table after reset
  always_ff @(posedge clk) begin
    if (busy) tbl[sweep] <= 2'b00;
    else if (commit) tbl[hidx] <= nxt;
    if (push) q[tail] <= {upd_idx, upd_taken};
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= INIT;
      sweep      <= '0;
      head       <= '0;
      tail       <= '0;
      q_count    <= '0;
      defer      <= '0;
      pred_valid <= 1'b0;
      pred_taken <= 1'b0;
    end else begin
      if (state == INIT) begin
        sweep <= sweep + 1'b1;
        if (sweep == '1) state <= RUN;
      end
      head       <= head + AW'(commit);
      tail       <= tail + AW'(push);
      q_count    <= q_count + CW'(push) - CW'(commit);
      defer      <= (commit || q_count == '0) ? '0 : lk ? defer + 1'b1 : defer;
      pred_valid <= lk;
      if (lk) pred_taken <= tbl[lookup_idx][1];
    end
  end
endmodule

// File: tb/tb_bpred_table_ctrl.sv
// tb_bpred_table_ctrl: cycle reference model with a prediction scoreboard for bpred_table_ctrl
module tb_bpred_table_ctrl;
  logic clk, reset, lookup_valid, lookup_ready, pred_valid, pred_taken;
  logic upd_valid, upd_taken, upd_ready, busy;
  logic [3:0] lookup_idx, upd_idx;
  logic [2:0] q_count;
  int nvec, nerr, msw, mdef;
  logic [1:0] mtbl [16];
  logic [4:0] mq [$];
  logic sb [$];
  logic dummy;

  bpred_table_ctrl #(.IDX_W(4), .QDEPTH(4), .MAX_DEFER(3)) dut (
    .clk(clk), .reset(reset), .lookup_valid(lookup_valid), .lookup_idx(lookup_idx),
    .lookup_ready(lookup_ready), .pred_valid(pred_valid), .pred_taken(pred_taken),
    .upd_valid(upd_valid), .upd_idx(upd_idx), .upd_taken(upd_taken),
    .upd_ready(upd_ready), .busy(busy), .q_count(q_count)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick(input logic lv, input logic [3:0] li, input logic uv,
                      input logic [3:0] ui, input logic ut, output logic acc);
    logic bz, ur, lr, lk, cm, e;
    logic [4:0] h;
    int sz;
    lookup_valid = lv; lookup_idx = li; upd_valid = uv; upd_idx = ui; upd_taken = ut;
    #1;
    sz = mq.size();
    bz = msw < 16;
    ur = !bz && sz < 4;
    lr = !bz && !(sz > 0 && mdef == 3);
    chk("busy", 32'(busy), 32'(bz));
    chk("upd_ready", 32'(upd_ready), 32'(ur));
    chk("lookup_ready", 32'(lookup_ready), 32'(lr));
    chk("q_count", 32'(q_count), 32'(sz));
    chk("pred_valid", 32'(pred_valid), 32'(sb.size() != 0));
    if (sb.size() != 0) begin
      e = sb.pop_front();
      chk("pred_taken", 32'(pred_taken), 32'(e));
    end
    lk = lv && lr;
    cm = !bz && sz > 0 && !lk;
    acc = uv && ur;
    if (lk) sb.push_back(mtbl[li][1]);
    if (bz) begin mtbl[msw] = 2'b00; msw++; end
    if (cm) begin
      h = mq.pop_front();
      if (h[0]) mtbl[h[4:1]] = (mtbl[h[4:1]] == 2'b11) ? 2'b11 : mtbl[h[4:1]] + 2'b01;
      else      mtbl[h[4:1]] = (mtbl[h[4:1]] == 2'b00) ? 2'b00 : mtbl[h[4:1]] - 2'b01;
    end
    if (acc) mq.push_back({ui, ut});
    mdef = (cm || sz == 0) ? 0 : lk ? mdef + 1 : mdef;
    @(negedge clk);
  endtask

  task automatic do_reset();
    lookup_valid = 0; upd_valid = 0; lookup_idx = 0; upd_idx = 0; upd_taken = 0;
    #2 reset = 1;
    #1;
    chk("rst_busy", 32'(busy), 32'd1);
    chk("rst_q_count", 32'(q_count), 32'd0);
    chk("rst_pred_valid", 32'(pred_valid), 32'd0);
    chk("rst_upd_ready", 32'(upd_ready), 32'd0);
    chk("rst_lookup_ready", 32'(lookup_ready), 32'd0);
    @(negedge clk);
    reset = 0;
    msw = 0; mdef = 0; mq.delete(); sb.delete();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(0, 4'd0, 0, 4'd0, 0, dummy);
  endtask

  task automatic look(input logic [3:0] idx);
    tick(1, idx, 0, 4'd0, 0, dummy);
    idle(1);
  endtask

  task automatic train(input logic [3:0] idx, input logic t);
    tick(0, 4'd0, 1, idx, t, dummy);
    idle(1);
  endtask

  initial begin
    logic [3:0] ui;
    logic ut, a;
    int k;
    nvec = 0; nerr = 0; reset = 1;
    do_reset();
    idle(16);
    look(4'd3);
    train(4'd5, 1); train(4'd5, 1); look(4'd5);
    train(4'd5, 1); look(4'd5);
    train(4'd5, 0); look(4'd5);
    train(4'd5, 0); look(4'd5);
    k = 0; ui = 4'($urandom); ut = 1'($urandom);
    for (int c = 0; c < 50; c++) begin
      tick(1, 4'($urandom_range(15)), k < 8, ui, ut, a);
      if (a) begin k++; ui = 4'($urandom); ut = 1'($urandom); end
    end
    chk("upd_pushed", 32'(k), 32'd8);
    for (int c = 0; c < 10 && mq.size() > 0; c++) idle(1);
    for (int i = 0; i < 16; i++) tick(1, 4'(i), 0, 4'd0, 0, dummy);
    idle(1);
    tick(0, 4'd0, 1, 4'd9, 1, dummy);
    tick(1, 4'd9, 0, 4'd0, 0, dummy);
    tick(1, 4'd9, 0, 4'd0, 0, dummy);
    idle(2);
    look(4'd9);
    train(4'd2, 1); train(4'd2, 1); train(4'd2, 1); look(4'd2);
    tick(1, 4'd0, 1, 4'd2, 1, dummy);
    tick(1, 4'd0, 1, 4'd2, 0, dummy);
    tick(1, 4'd0, 1, 4'd7, 1, dummy);
    chk("pre_rst_q_count", 32'(q_count), 32'd3);
    do_reset();
    idle(16);
    look(4'd2);
    idle(1);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
